adc128_spi_responder: RTL and testbench
=======================================

Name: adc128_spi_responder

Overview:
- Synthesizable device-side model of the 8-channel, 12-bit serial ADC (ADC128S022-style) on the IMU depth/accelerometer path.
- Answers the ADC_CS_N / ADC_SCLK / ADC_SADDR frames the IMU sampler drives, and returns per-channel values on ADC_SDAT.
- Per-channel values are preloaded through a simple write port.
- Used for hardware-in-loop and bench testing of the IMU Avalon readout without the physical converter.

Parameters:
- NUM_CH, 8, number of channel value registers (address field is 3 bits)
- DATA_W, 12, conversion width; frame carries 16-DATA_W leading zeros
- FRAME_BITS, 16, SCLK cycles per frame
- SYNC_STAGES, 2, flops in each input synchronizer

Ports:
- clk  in  1  system clock; must be >= 8x ADC_SCLK frequency
- reset_n  in  1  asynchronous active-low reset
- load_en  in  1  write strobe for a channel value
- load_ch  in  3  channel index to write
- load_data  in  DATA_W  value for load_ch
- ADC_CS_N  in  1  frame select from the initiator, active low
- ADC_SCLK  in  1  serial clock from the initiator
- ADC_SADDR  in  1  serial address (DIN) from the initiator
- ADC_SDAT  out  1  serial conversion data (DOUT), MSB first
- frame_done  out  1  one-clk pulse after a complete 16-bit frame
- cur_ch  out  3  channel whose value the next frame will return

Behaviour:
- Clock/reset: one clock domain, clk. reset_n is asynchronous and active-low.
- Reset values: ADC_SDAT=0, frame_done=0, cur_ch=0, all channel registers=0, state=IDLE, bit_cnt=0.
- Input synchronization: ADC_CS_N, ADC_SCLK and ADC_SADDR each pass through SYNC_STAGES flops.
  - Edge detect uses one further delayed copy.
  - The synchronizer flops reset CS_N high and SCLK high.
  - Every pin-to-action latency is SYNC_STAGES+1 clk cycles.
- States:
  - IDLE:
    - On a synchronized CS_N falling edge, load shift_reg = {zeros, chan[cur_ch]}, clear bit_cnt and addr_sr, go to SHIFT.
    - ADC_SDAT drives shift_reg MSB (0) on the same cycle.
  - SHIFT, SCLK rising edge:
    - bit_cnt increments.
    - ADC_SADDR is sampled into addr_sr when bit_cnt (pre-increment) is 2, 3 or 4 (ADD2, ADD1, ADD0).
  - SHIFT, SCLK falling edge:
    - shift_reg shifts left and ADC_SDAT takes the new MSB.
    - After bit_cnt has reached FRAME_BITS, ADC_SDAT holds 0.
  - SHIFT, frame completion: on the rising edge that makes bit_cnt reach FRAME_BITS:
    - cur_ch <= addr_sr.
    - frame_done pulses for 1 clk.
    - State stays SHIFT until CS_N rises.
  - SHIFT, CS_N rising edge:
    - Go to IDLE and set ADC_SDAT=0.
    - If bit_cnt < FRAME_BITS (aborted frame): cur_ch is unchanged and frame_done is not pulsed.
- Pipelined addressing: frame N returns the value for the channel addressed in frame N-1. The first frame after reset returns channel 0.
- Snapshot rule: the returned value is captured at CS_N fall.
  - A load_en to any channel, including the one in flight, changes only later frames.
  - load_en is accepted in any state, every cycle.
- Extra SCLK edges (more than FRAME_BITS while CS_N low): bit_cnt saturates at FRAME_BITS, ADC_SDAT=0, cur_ch is not re-latched.
- Simultaneous SCLK and CS_N edges in the same synchronized cycle: the CS_N edge wins. A CS_N fall starts the frame and ignores that SCLK edge.
- load_ch >= NUM_CH: write is ignored.

Decomposition:
- Shared package imu_pkg:
  - ADC_DATA_W, ADC_FRAME_BITS, ADC_ADDR_W=3
  - address bit positions ADDR_FIRST_BIT=2, ADDR_LAST_BIT=4
  - state encoding IDLE/SHIFT
- One natural sub-module, sync_edge_detect: a SYNC_STAGES synchronizer plus rise/fall pulse outputs, instanced three times (edge outputs unused for SADDR).

Test Plan:
- Reset, then load ch0=0xABC and run a 16-SCLK frame with SADDR bits 2..4 = 011 -> SDAT bitstream 0000_1010_1011_1100, frame_done pulses once, cur_ch=3.
- Load ch3=0x5A5, then run a second frame with address 000 -> returns 0000_0101_1010_0101 and cur_ch=0.
- Abort: raise CS_N after 8 SCLKs with address 111 -> no frame_done, cur_ch unchanged at its prior value, SDAT=0 while CS_N is high.
- Mid-frame load: during a frame returning ch0=0x123, write ch0=0xFFF at SCLK 6 -> that frame still returns 0x123 and the next frame on ch0 returns 0xFFF.
- 20 SCLKs within one CS_N low window, address 101 -> bits 17-20 read 0, exactly one frame_done, cur_ch=5.
- Assert reset_n low mid-frame at SCLK 9 -> SDAT=0 and cur_ch=0 immediately (asynchronously); the next frame returns ch0 after reset (0x000).

Source files
------------

// File: rtl/imu_pkg.sv
// imu_pkg: shared constants and state encoding for the IMU ADC responder.
package imu_pkg;
  localparam int ADC_NUM_CH      = 8;
  localparam int ADC_DATA_W      = 12;
  localparam int ADC_FRAME_BITS  = 16;
  localparam int ADC_ADDR_W      = 3;
  localparam int ADC_SYNC_STAGES = 2;
  localparam int ADDR_FIRST_BIT  = 2;
  localparam int ADDR_LAST_BIT   = 4;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} adc_state_e;

  function automatic logic in_addr_window(input int cnt);
    return cnt >= ADDR_FIRST_BIT && cnt <= ADDR_LAST_BIT;
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop input synchronizer with registered-delay edge pulses.
module sync_edge_detect #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              dly_q, dly_d;

  always_comb begin
    sync_d = STAGES'({sync_q, d});
    dly_d  = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~dly_q;
  assign fall = ~q & dly_q;
endmodule

// File: rtl/adc128_spi_responder.sv
// adc128_spi_responder: device-side model of an 8-channel 12-bit serial ADC,
// returning preloaded channel values with one-frame-pipelined addressing.
module adc128_spi_responder
  import imu_pkg::*;
#(
  parameter int NUM_CH      = ADC_NUM_CH,
  parameter int DATA_W      = ADC_DATA_W,
  parameter int FRAME_BITS  = ADC_FRAME_BITS,
  parameter int SYNC_STAGES = ADC_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_en,
  input  logic [ADC_ADDR_W-1:0] load_ch,
  input  logic [DATA_W-1:0]     load_data,
  input  logic                  ADC_CS_N,
  input  logic                  ADC_SCLK,
  input  logic                  ADC_SADDR,
  output logic                  ADC_SDAT,
  output logic                  frame_done,
  output logic [ADC_ADDR_W-1:0] cur_ch
);
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS);

  logic cs_rise, cs_fall, sclk_rise, sclk_fall, saddr_s;
  logic cs_lvl_unused, sclk_lvl_unused, saddr_rise_unused, saddr_fall_unused;

  adc_state_e            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [ADC_ADDR_W-1:0] addr_q, addr_d, cur_ch_q, cur_ch_d;
  logic                  sdat_q, sdat_d, done_q, done_d;
  logic [DATA_W-1:0]     chan_q [NUM_CH];
  logic [DATA_W-1:0]     chan_d [NUM_CH];

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset_n(reset_n), .d(ADC_CS_N),
    .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
    .clk(clk), .reset_n(reset_n), .d(ADC_SCLK),
    .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_saddr (
    .clk(clk), .reset_n(reset_n), .d(ADC_SADDR),
    .q(saddr_s), .rise(saddr_rise_unused), .fall(saddr_fall_unused)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    cur_ch_d  = cur_ch_q;
    sdat_d    = sdat_q;
    done_d    = 1'b0;
    chan_d    = chan_q;
    if (load_en && int'(load_ch) < NUM_CH) chan_d[load_ch] = load_data;
    // CS_N edges take priority over any SCLK edge seen in the same cycle
    if (state_q == IDLE) begin
      sdat_d = 1'b0;
      if (cs_fall) begin
        shift_d   = FRAME_BITS'(chan_q[cur_ch_q]);
        bit_cnt_d = '0;
        addr_d    = '0;
        state_d   = SHIFT;
        sdat_d    = shift_d[FRAME_BITS-1];
      end
    end else if (cs_rise) begin
      state_d = IDLE;
      sdat_d  = 1'b0;
    end else if (sclk_rise) begin
      if (bit_cnt_q != LAST) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (in_addr_window(int'(bit_cnt_q))) addr_d = {addr_q[ADC_ADDR_W-2:0], saddr_s};
        if (bit_cnt_d == LAST) begin
          cur_ch_d = addr_d;
          done_d   = 1'b1;
        end
      end
    end else if (sclk_fall) begin
      shift_d = shift_q << 1;
      sdat_d  = (bit_cnt_q == LAST) ? 1'b0 : shift_d[FRAME_BITS-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      cur_ch_q  <= '0;
      sdat_q    <= 1'b0;
      done_q    <= 1'b0;
      chan_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      cur_ch_q  <= cur_ch_d;
      sdat_q    <= sdat_d;
      done_q    <= done_d;
      chan_q    <= chan_d;
    end
  end

  assign ADC_SDAT   = sdat_q;
  assign frame_done = done_q;
  assign cur_ch     = cur_ch_q;
endmodule

// File: tb/tb_adc128_spi_responder.sv
// tb_adc128_spi_responder: randomized frames checked against a frame-level
// model of channel registers and one-frame-pipelined addressing.
module tb_adc128_spi_responder;
  localparam int H = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_en = 1'b0;
  logic [2:0]  load_ch = '0;
  logic [11:0] load_data = '0;
  logic        cs_n = 1'b1, sclk = 1'b1, saddr = 1'b0;
  logic        sdat, frame_done;
  logic [2:0]  cur_ch;

  int checks = 0, failures = 0, done_total = 0;
  logic [11:0] m_chan [8];
  logic [2:0]  m_cur;

  adc128_spi_responder dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_ch(load_ch),
    .load_data(load_data), .ADC_CS_N(cs_n), .ADC_SCLK(sclk), .ADC_SADDR(saddr),
    .ADC_SDAT(sdat), .frame_done(frame_done), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done) done_total <= done_total + 1;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 8; c++) m_chan[c] = '0;
    m_cur = '0;
  endtask

  task automatic do_load(input logic [2:0] ch, input logic [11:0] d);
    load_en = 1'b1; load_ch = ch; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    m_chan[ch] = d;
  endtask

  task automatic run_frame(input string name, input logic [2:0] addr, input int nsclk,
                           input int mid_at, input logic [2:0] mid_ch, input logic [11:0] mid_data);
    logic [15:0] frame;
    logic [31:0] got, exp;
    int          done0, ndone, exp_done;
    logic [2:0]  exp_cur;
    frame = {4'b0, m_chan[m_cur]};
    got = '0; exp = '0;
    done0 = done_total;
    sclk = 1'b0; wait_clk(H);
    cs_n = 1'b0; wait_clk(H);
    for (int i = 0; i < nsclk; i++) begin
      saddr = (i == 2) ? addr[2] : (i == 3) ? addr[1] : (i == 4) ? addr[0] : 1'($urandom);
      if (i == mid_at) do_load(mid_ch, mid_data);
      wait_clk(H);
      got[i] = sdat;
      exp[i] = (i < 16) ? frame[15 - i] : 1'b0;
      sclk = 1'b1; wait_clk(H);
      sclk = 1'b0;
    end
    wait_clk(H);
    cs_n = 1'b1; wait_clk(6);
    ndone = done_total - done0;
    exp_done = (nsclk >= 16) ? 1 : 0;
    exp_cur = (nsclk >= 16) ? addr : m_cur;
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s sdat_bits: got %h expected %h (n=%0d)", name, got, exp, nsclk);
    end
    checks++;
    if (ndone !== exp_done) begin
      failures++;
      $display("FAIL %s frame_done_count: got %0d expected %0d", name, ndone, exp_done);
    end
    checks++;
    if (cur_ch !== exp_cur) begin
      failures++;
      $display("FAIL %s cur_ch: got %0d expected %0d", name, cur_ch, exp_cur);
    end
    checks++;
    if (sdat !== 1'b0) begin
      failures++;
      $display("FAIL %s sdat_idle: got %b expected 0", name, sdat);
    end
    m_cur = exp_cur;
    sclk = 1'b1; wait_clk(H);
  endtask

  task automatic test_reset();
    model_reset();
    wait_clk(3);
    checks++;
    if ({sdat, frame_done, cur_ch} !== 5'b0) begin
      failures++;
      $display("FAIL reset_in: got sdat=%b done=%b cur=%0d expected 0/0/0", sdat, frame_done, cur_ch);
    end
    reset_n = 1'b1;
    wait_clk(5);
    checks++;
    if ({sdat, frame_done, cur_ch} !== 5'b0) begin
      failures++;
      $display("FAIL reset_after: got sdat=%b done=%b cur=%0d expected 0/0/0", sdat, frame_done, cur_ch);
    end
  endtask

  task automatic test_basic();
    do_load(3'd0, 12'hABC);
    run_frame("basic", 3'b011, 16, -1, 3'd0, 12'h0);
    do_load(3'd3, 12'h5A5);
    run_frame("second", 3'b000, 16, -1, 3'd0, 12'h0);
  endtask

  task automatic test_abort();
    run_frame("abort", 3'b111, 8, -1, 3'd0, 12'h0);
  endtask

  task automatic test_mid_load();
    do_load(3'd0, 12'h123);
    run_frame("mid_load", 3'b000, 16, 6, 3'd0, 12'hFFF);
    run_frame("after_mid_load", 3'b000, 16, -1, 3'd0, 12'h0);
  endtask

  task automatic test_extra_sclk();
    run_frame("extra_sclk", 3'b101, 20, -1, 3'd0, 12'h0);
  endtask

  task automatic test_reset_mid_frame();
    do_load(3'd5, 12'hFFF);
    sclk = 1'b0; wait_clk(H);
    cs_n = 1'b0; wait_clk(H);
    for (int i = 0; i < 9; i++) begin
      wait_clk(H); sclk = 1'b1;
      wait_clk(H); sclk = 1'b0;
    end
    wait_clk(H);
    checks++;
    if (sdat !== 1'b1 || cur_ch !== 3'd5) begin
      failures++;
      $display("FAIL pre_reset: got sdat=%b cur=%0d expected 1/5", sdat, cur_ch);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (sdat !== 1'b0 || cur_ch !== 3'd0) begin
      failures++;
      $display("FAIL async_reset: got sdat=%b cur=%0d expected 0/0", sdat, cur_ch);
    end
    cs_n = 1'b1; sclk = 1'b1;
    wait_clk(3);
    reset_n = 1'b1;
    model_reset();
    wait_clk(4);
    run_frame("post_reset", 3'($urandom), 16, -1, 3'd0, 12'h0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      int r, n, mid;
      if ($urandom_range(0, 1) == 1) do_load(3'($urandom), 12'($urandom));
      if ($urandom_range(0, 1) == 1) do_load(3'($urandom), 12'($urandom));
      r = $urandom_range(0, 5);
      n = (r == 0) ? $urandom_range(1, 15) : (r == 1) ? $urandom_range(17, 22) : 16;
      mid = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      run_frame("random", 3'($urandom), n, mid, 3'($urandom), 12'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_mid_load();
    test_extra_sclk();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
